regfile_rd: RTL

- Integer register file for the riscx core: one writeback port and two registered read ports (rs1, rs2) feeding decode/execute.
- Includes a per-register pending scoreboard, so issue logic can stall on operands whose producer has not yet written back.
- Read data and busy flags are registered: 1-cycle latency from address to data.

---
 rtl/regfile_rd.sv | 96 +++++++++
 1 files changed

// File: rtl/regfile_rd.sv
// Integer register file with one writeback port, two registered read ports and a pending scoreboard.
// Build option REGFILE_RD_BYPASS_EN: a read that coincides with a writeback to the same index returns the new value.
module regfile_rd #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rs1_en,
  input  logic [AW-1:0]   rs1_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic            rs1_busy,
  input  logic            rs2_en,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs2_busy,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_rd
);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] pending;
  logic [NREG-1:0] pending_next;
  logic            wb_live;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;

  assign wb_live = wb_en && (wb_addr != '0);

  // Issue is applied after writeback so a same-cycle newer producer keeps the bit set.
  always_comb begin
    pending_next = pending;
    if (wb_live)
      pending_next[wb_addr] = 1'b0;
    if (iss_en && (iss_rd != '0))
      pending_next[iss_rd] = 1'b1;
    pending_next[0] = 1'b0;
  end

  always_comb begin
    rs1_val = regs[rs1_addr];
    rs2_val = regs[rs2_addr];
`ifdef REGFILE_RD_BYPASS_EN
    if (wb_live && (wb_addr == rs1_addr))
      rs1_val = wb_data;
    if (wb_live && (wb_addr == rs2_addr))
      rs2_val = wb_data;
`endif
    if (rs1_addr == '0)
      rs1_val = '0;
    if (rs2_addr == '0)
      rs2_val = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++)
        regs[i] <= '0;
    end else begin
      regs[0] <= '0;
      for (int i = 1; i < NREG; i++)
        if (wb_en && (wb_addr == AW'(i)))
          regs[i] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pending <= '0;
    else
      pending <= pending_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs1_data <= '0;
      rs1_busy <= 1'b0;
      rs2_data <= '0;
      rs2_busy <= 1'b0;
    end else begin
      if (rs1_en) begin
        rs1_data <= rs1_val;
        rs1_busy <= pending_next[rs1_addr];
      end
      if (rs2_en) begin
        rs2_data <= rs2_val;
        rs2_busy <= pending_next[rs2_addr];
      end
    end
  end

endmodule
